// File: rtl/calc_pkg.sv
// Shared calculator definitions: divider FSM states and the default operand/result widths
// used by both the multiply and divide units.
package calc_pkg;

   localparam int CALC_OPERAND_W = 4;
   localparam int CALC_RESULT_W  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage : calc_pkg

// File: rtl/sequential_division_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
interface sequential_division_if
   import calc_pkg::*;
#(
   parameter int DIVIDEND_W = CALC_RESULT_W,
   parameter int DIVISOR_W  = CALC_OPERAND_W
) ();

   logic                  start;
   logic [DIVIDEND_W-1:0] dividend;
   logic [DIVISOR_W-1:0]  divisor;
   logic                  busy;
   logic                  done;
   logic [DIVIDEND_W-1:0] quotient;
   logic [DIVISOR_W-1:0]  remainder;
   logic                  div_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_zero
   );

endinterface : sequential_division_if

// File: rtl/sequential_division_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the
// divisor, keep the difference when it does not go negative.
module div_step #(
   parameter int DIVISOR_W = 4
) (
   input  logic [DIVISOR_W:0]   i_rem,
   input  logic                 i_bit,
   input  logic [DIVISOR_W-1:0] i_divisor,
   output logic [DIVISOR_W:0]   o_rem,
   output logic                 o_q
);

   logic [DIVISOR_W+1:0] w_shift;
   logic [DIVISOR_W:0]   w_diff;

   assign w_shift = {i_rem, i_bit};
   // Only the low bits of the difference matter: when it is kept it fits in DIVISOR_W+1 bits.
   assign w_diff  = w_shift[DIVISOR_W:0] - {1'b0, i_divisor};
   assign o_q     = (w_shift >= {2'b00, i_divisor});
   assign o_rem   = o_q ? w_diff : w_shift[DIVISOR_W:0];

endmodule : div_step

// File: rtl/sequential_division.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional macro DIV_ZERO_DETECT_EN: zero divisor skips iteration and flags div_zero.
module sequential_division
   import calc_pkg::*;
#(
   parameter int DIVIDEND_W = CALC_RESULT_W,
   parameter int DIVISOR_W  = CALC_OPERAND_W
) (
   input logic                  clk,
   input logic                  rst,
   sequential_division_if.slave bus
);

   localparam int                CNT_W    = $clog2(DIVIDEND_W + 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DIVIDEND_W);

   div_state_t            r_state;
   div_state_t            w_next_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [DIVIDEND_W-1:0] r_dvd;
   logic [DIVISOR_W-1:0]  r_dvs;
   logic [DIVISOR_W:0]    r_rem;
   logic [DIVIDEND_W-1:0] r_quot;
   logic [DIVISOR_W-1:0]  r_rem_out;
   logic                  r_div_zero;

   logic                  w_accept;
   logic                  w_last;
   logic                  w_zero;
   logic [DIVISOR_W:0]    w_step_rem;
   logic                  w_step_q;

`ifdef DIV_ZERO_DETECT_EN
   assign w_zero = (bus.divisor == {DIVISOR_W{1'b0}});
`else
   assign w_zero = 1'b0;
`endif

   assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));
   assign w_last   = (r_state == RUN) && (r_cnt == CNT_ONE);

   div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
      .i_rem     (r_rem),
      .i_bit     (r_dvd[DIVIDEND_W-1]),
      .i_divisor (r_dvs),
      .o_rem     (w_step_rem),
      .o_q       (w_step_q)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode; DONE accepts a new start just like IDLE.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE, DONE: begin
            if (bus.start) begin
               w_next_state = w_zero ? DONE : RUN;
            end else begin
               w_next_state = IDLE;
            end
         end
         RUN: begin
            if (r_cnt == CNT_ONE) begin
               w_next_state = DONE;
            end else begin
               w_next_state = RUN;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Datapath: quotient bits shift into the dividend register as its bits are consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= {CNT_W{1'b0}};
         r_dvd      <= {DIVIDEND_W{1'b0}};
         r_dvs      <= {DIVISOR_W{1'b0}};
         r_rem      <= {(DIVISOR_W + 1){1'b0}};
         r_quot     <= {DIVIDEND_W{1'b0}};
         r_rem_out  <= {DIVISOR_W{1'b0}};
         r_div_zero <= 1'b0;
      end else if (w_accept) begin
         r_dvd <= bus.dividend;
         r_dvs <= bus.divisor;
         r_rem <= {(DIVISOR_W + 1){1'b0}};
         r_cnt <= CNT_LOAD;
         if (w_zero) begin
            r_quot     <= {DIVIDEND_W{1'b1}};
            r_rem_out  <= bus.dividend[DIVISOR_W-1:0];
            r_div_zero <= 1'b1;
         end
      end else if (r_state == RUN) begin
         r_dvd <= {r_dvd[DIVIDEND_W-2:0], w_step_q};
         r_rem <= w_step_rem;
         r_cnt <= r_cnt - CNT_ONE;
         if (w_last) begin
            r_quot     <= {r_dvd[DIVIDEND_W-2:0], w_step_q};
            r_rem_out  <= w_step_rem[DIVISOR_W-1:0];
            r_div_zero <= 1'b0;
         end
      end
   end

   assign bus.busy      = (r_state == RUN);
   assign bus.done      = (r_state == DONE);
   assign bus.quotient  = r_quot;
   assign bus.remainder = r_rem_out;
   assign bus.div_zero  = r_div_zero;

endmodule : sequential_division

// File: tb/tb_sequential_division.sv
// Self-checking bench for sequential_division: cycle-level behavioural model plus directed,
// random and exhaustive operand runs.
module tb_sequential_division;

`ifdef DIV_ZERO_DETECT_EN
   localparam bit ZD = 1'b1;
`else
   localparam bit ZD = 1'b0;
`endif
   localparam int LAT = 9;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   bit   mon_en = 1'b0;

   sequential_division_if #(.DIVIDEND_W(8), .DIVISOR_W(4)) bus ();

   sequential_division #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: an operation either finishes instantly (detected zero divisor) or
   // after 8 busy cycles; results are integer div/mod.
   bit         m_busy = 1'b0, m_done = 1'b0, m_z = 1'b0, p_z = 1'b0;
   int         m_left = 0;
   logic [7:0] m_q = 8'd0, p_q = 8'd0;
   logic [3:0] m_r = 4'd0, p_r = 4'd0;

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 1'b0; m_done = 1'b0; m_left = 0;
         m_q = 8'd0; m_r = 4'd0; m_z = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0; m_done = 1'b1;
               m_q = p_q; m_r = p_r; m_z = p_z;
            end
         end else if (bus.start === 1'b1) begin
            if (bus.divisor == 4'd0) begin
               p_q = 8'hFF; p_r = bus.dividend[3:0]; p_z = ZD;
            end else begin
               p_q = 8'(int'(bus.dividend) / int'(bus.divisor));
               p_r = 4'(int'(bus.dividend) % int'(bus.divisor));
               p_z = 1'b0;
            end
            if (ZD && bus.divisor == 4'd0) begin
               m_done = 1'b1; m_q = p_q; m_r = p_r; m_z = p_z;
            end else begin
               m_busy = 1'b1; m_left = 8;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("busy", 32'(bus.busy), 32'(m_busy));
         chk("done", 32'(bus.done), 32'(m_done));
         chk("quotient", 32'(bus.quotient), 32'(m_q));
         chk("remainder", 32'(bus.remainder), 32'(m_r));
         chk("div_zero", 32'(bus.div_zero), 32'(m_z));
      end
   end

   // Issue one operation and wait (bounded) for done; returns cycles from start to done.
   task automatic run_op(input logic [7:0] a, input logic [3:0] b, input bit noise,
                         output int lat);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.dividend = 8'($urandom); bus.divisor = 4'($urandom);
      lat = 1;
      while (bus.done !== 1'b1 && lat < 20) begin
         bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      bus.start = 1'b0;
      chk("done_timeout", 32'(bus.done), 32'd1);
   endtask

   task automatic run_chk(input string name, input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] eq, input logic [3:0] er, input bit ez,
                          input int elat);
      int lat;
      run_op(a, b, 1'b0, lat);
      chk({name, "_lat"}, 32'(lat), 32'(elat));
      chk({name, "_q"}, 32'(bus.quotient), 32'(eq));
      chk({name, "_r"}, 32'(bus.remainder), 32'(er));
      chk({name, "_z"}, 32'(bus.div_zero), 32'(ez));
   endtask

   initial begin
      int lat;
      int busy_cnt;
      logic [7:0] a;
      logic [3:0] b;
      bus.start = 1'b0; bus.dividend = 8'd0; bus.divisor = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_q", 32'(bus.quotient), 32'd0);
      chk("reset_r", 32'(bus.remainder), 32'd0);

      // 200/13 with busy-length measurement
      @(posedge clk); #1;
      bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd13;
      @(posedge clk); #1;
      bus.start = 1'b0;
      busy_cnt = 0; lat = 1;
      while (bus.done !== 1'b1 && lat < 20) begin
         if (bus.busy === 1'b1) busy_cnt++;
         @(posedge clk); #1;
         lat++;
      end
      chk("d200_lat", 32'(lat), 32'(LAT));
      chk("d200_busy", 32'(busy_cnt), 32'd8);
      chk("d200_q", 32'(bus.quotient), 32'd15);
      chk("d200_r", 32'(bus.remainder), 32'd5);

      // 255/1 then 7/9 started in the DONE cycle
      run_chk("d255", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0, LAT);
      bus.start = 1'b1; bus.dividend = 8'd7; bus.divisor = 4'd9;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("b2b_busy", 32'(bus.busy), 32'd1);
      lat = 1;
      while (bus.done !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("d7_lat", 32'(lat), 32'(LAT));
      chk("d7_q", 32'(bus.quotient), 32'd0);
      chk("d7_r", 32'(bus.remainder), 32'd7);

      // zero divisor
      run_chk("dzero", 8'hA5, 4'd0, 8'hFF, 4'd5, ZD, ZD ? 1 : LAT);

      // start pulses during RUN must be ignored
      @(posedge clk); #1;
      bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 4'd7;
      @(posedge clk); #1;
      bus.dividend = 8'd3; bus.divisor = 4'd2;
      lat = 1;
      while (bus.done !== 1'b1 && lat < 20) begin
         bus.start = (lat < 8) ? 1'b1 : 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      bus.start = 1'b0;
      chk("d100_lat", 32'(lat), 32'(LAT));
      chk("d100_q", 32'(bus.quotient), 32'd14);
      chk("d100_r", 32'(bus.remainder), 32'd2);

      // reset in the 4th RUN cycle
      @(posedge clk); #1;
      bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 4'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_q", 32'(bus.quotient), 32'd0);
      chk("rst_r", 32'(bus.remainder), 32'd0);
      chk("rst_z", 32'(bus.div_zero), 32'd0);
      lat = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) lat++;
      end
      chk("rst_no_done", 32'(lat), 32'd0);
      run_chk("d9", 8'd9, 4'd3, 8'd3, 4'd0, 1'b0, LAT);

      // random operations with start noise while busy
      repeat (200) begin
         a = 8'($urandom);
         b = 4'($urandom_range(0, 15));
         run_op(a, b, 1'b1, lat);
         chk("rand_lat", 32'(lat), 32'((ZD && b == 4'd0) ? 1 : LAT));
      end

      // exhaustive sweep of nonzero divisors
      for (int i = 0; i < 256; i++) begin
         for (int j = 1; j < 16; j++) begin
            run_op(8'(i), 4'(j), 1'b0, lat);
            chk("sweep_q", 32'(bus.quotient), 32'(i / j));
            chk("sweep_r", 32'(bus.remainder), 32'(i % j));
         end
      end

      @(negedge clk);
      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_sequential_division

// File: doc/sequential_division.md
Name: sequential_division

Overview:
Multi-cycle restoring divider for the calculator datapath. It is the inverse companion of the shift-and-add multiply unit. It takes an unsigned dividend and divisor, iterates one quotient bit per clock, and returns quotient and remainder using a start/busy/done handshake. The calculator control FSM launches it for the divide operation and captures results on done.

Parameters:
- DIVIDEND_W, 8, dividend and quotient width in bits (matches the multiply product width)
- DIVISOR_W, 4, divisor and remainder width in bits (matches the multiply operand width)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only in IDLE or DONE
- dividend  input  DIVIDEND_W  unsigned dividend, captured on accepted start
- divisor  input  DIVISOR_W  unsigned divisor, captured on accepted start
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse when results become valid
- quotient  output  DIVIDEND_W  result quotient, held until next accepted start
- remainder  output  DIVISOR_W  result remainder, held until next accepted start
- div_zero  output  1  divisor was zero (see Optional Feature), held with results

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous, active-high. On rst the FSM goes to IDLE and busy, done, quotient, remainder and div_zero all become 0.
- FSM states:
  - IDLE: start=1 captures operands, clears the partial remainder (DIVISOR_W+1 bits), loads the step counter with DIVIDEND_W, and moves to RUN.
  - RUN: each cycle performs one restoring step on the next dividend bit, MSB first:
    - shift the partial remainder left and bring in the dividend bit;
    - trial subtract the zero-extended divisor;
    - if the result is non-negative, keep it and shift quotient bit 1; otherwise restore and shift 0;
    - decrement the counter; when it reaches 0, go to DONE.
  - DONE: done=1 for exactly this cycle; then IDLE. start=1 in DONE is accepted exactly as in IDLE (back-to-back operation).
- busy=1 in RUN only. start while busy is ignored, with no effect on the operation in flight.
- Latency: start sampled at edge N gives busy from N+1 through N+DIVIDEND_W, and done plus valid results at N+DIVIDEND_W+1.
- Result registers update only on the DONE transition. Between operations they hold their last values, and they are not cleared on start.
- Operand inputs may change after acceptance without effect.
- Divisor = 0 without the optional feature: the algorithm runs naturally, giving quotient all ones and remainder = dividend[DIVISOR_W-1:0]. div_zero stays 0.
- Reset mid-RUN aborts the operation. No done pulse is produced and outputs clear.
- All arithmetic is unsigned. No overflow is possible because quotient width equals dividend width.

Optional Feature:
- Macro DIV_ZERO_DETECT_EN.
- Defined: divisor==0 at start skips RUN and goes IDLE→DONE, so done arrives one cycle after start. Outputs in that case:
  - quotient all ones;
  - remainder = dividend[DIVISOR_W-1:0];
  - div_zero=1.
- Defined, nonzero divisor: div_zero=0.
- Undefined: div_zero is tied 0 and zero divisors take the full latency.

Decomposition:
- Shared package calc_pkg holds:
  - the div_state_t enum (IDLE, RUN, DONE);
  - default width constants CALC_OPERAND_W=4 and CALC_RESULT_W=8, shared with the multiply unit.
- Sub-module div_step is a purely combinational single restoring step. Inputs: partial remainder, next dividend bit, divisor. Outputs: new partial remainder and quotient bit. The main block holds the FSM, counter and registers.

Test Plan:
- dividend=200, divisor=13, start 1 cycle → done 9 cycles later, quotient=15, remainder=5, busy high 8 cycles.
- 255/1 then immediately 7/9 (start asserted in DONE cycle) → 255 r 0, then 0 r 7, with no idle gap.
- 0xA5/0 with DIV_ZERO_DETECT_EN → done 1 cycle after start, quotient=0xFF, remainder=5, div_zero=1. Without the macro → same values after 9 cycles, div_zero=0.
- start pulsed again mid-RUN with different operands → ignored; first result (100/7 = 14 r 2) is correct.
- rst asserted in 4th RUN cycle → next cycle busy=0, all outputs 0, no done. A following 9/3 returns 3 r 0.
- Exhaustive sweep of all dividend 0–255 × divisor 1–15 → quotient and remainder match the reference integer div/mod.
